// File: rtl/gpio_pkg.sv
// Shared definitions for the Avalon-MM GPIO controller: register word
// addresses and edge-capture type encodings.
package gpio_pkg;

  // Register word addresses
  localparam logic [2:0] GPIO_DATA    = 3'd0;
  localparam logic [2:0] GPIO_DIR     = 3'd1;
  localparam logic [2:0] GPIO_IRQMASK = 3'd2;
  localparam logic [2:0] GPIO_EDGECAP = 3'd3;
  localparam logic [2:0] GPIO_OUTSET  = 3'd4;
  localparam logic [2:0] GPIO_OUTCLR  = 3'd5;

  // Edge-capture type encodings (EDGE_TYPE parameter values)
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/gpio_edge_capture.sv
// Input path of the GPIO controller: synchroniser chain, previous-value
// register, post-reset warm-up counter, edge detector and the edge-capture
// register with a write-1-to-clear mask.
module gpio_edge_capture
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = EDGE_RISING,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  input  logic [WIDTH-1:0] clr_mask,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] edgecap
);

  // Edges are only trusted once the chain and in_prev hold post-reset samples.
  localparam int         WARM_CYCLES = SYNC_STAGES + 1;
  localparam logic [2:0] WARM_DONE   = 3'(WARM_CYCLES);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] in_prev_q, in_prev_d;
  logic [2:0]       warm_q, warm_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_det;
  logic             edge_en;

  assign in_sync = sync_q[SYNC_STAGES-1];
  assign edgecap = edgecap_q;
  assign edge_en = (warm_q == WARM_DONE);

  // Next-state for the synchroniser shift chain and the previous-value flop.
  always_comb begin
    sync_d[0] = in_port;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    in_prev_d = in_sync;
  end

  // Warm-up counter saturates at WARM_DONE and then holds.
  always_comb begin
    warm_d = warm_q;
    if (warm_q != WARM_DONE) begin
      warm_d = warm_q + 3'd1;
    end
  end

  // Edge detection selected by EDGE_TYPE, gated off during warm-up.
  always_comb begin
    edge_raw = '0;
    case (EDGE_TYPE)
      EDGE_RISING:  edge_raw = in_sync & ~in_prev_q;
      EDGE_FALLING: edge_raw = ~in_sync & in_prev_q;
      default:      edge_raw = in_sync ^ in_prev_q;
    endcase
    edge_det = edge_en ? edge_raw : '0;
  end

  // Capture register: a new edge beats a simultaneous clear of the same bit.
  always_comb begin
    edgecap_d = (edgecap_q & ~clr_mask) | edge_det;
  end

  // All input-path state, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      in_prev_q <= '0;
      warm_q    <= '0;
      edgecap_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      in_prev_q <= in_prev_d;
      warm_q    <= warm_d;
      edgecap_q <= edgecap_d;
    end
  end

endmodule

// File: rtl/avalon_gpio_ctrl.sv
// Avalon-MM slave GPIO controller: bus decode, output data register,
// direction and interrupt-mask registers, read mux and the level IRQ.
//
// Bus protocol: zero-wait-state slave with no waitrequest. A write is
// accepted on every clk edge where chipselect=1 and write_n=0; readdata is
// combinational from address and reading never changes state.
module avalon_gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_OUT   = 32'h0,
  parameter logic [31:0] RESET_DIR   = 32'h0,
  parameter int          EDGE_TYPE   = EDGE_RISING,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] rd_val;
  logic             unused_writedata;

  assign wr_en = chipselect & ~write_n;
  assign wd    = writedata[WIDTH-1:0];

  // Upper writedata bits carry nothing for narrow configurations.
  assign unused_writedata = ^writedata;

  gpio_edge_capture #(
    .WIDTH       (WIDTH),
    .EDGE_TYPE   (EDGE_TYPE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_capture (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .clr_mask (clr_mask),
    .in_sync  (in_sync),
    .edgecap  (edgecap)
  );

  // Register write decode, including atomic set/clear of output bits.
  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    irqmask_d = irqmask_q;
    clr_mask  = '0;
    if (wr_en) begin
      case (address)
        GPIO_DATA:    out_d     = wd;
        GPIO_DIR:     dir_d     = wd;
        GPIO_IRQMASK: irqmask_d = wd;
        GPIO_EDGECAP: clr_mask  = wd;
        GPIO_OUTSET:  out_d     = out_q | wd;
        GPIO_OUTCLR:  out_d     = out_q & ~wd;
        default:      ;
      endcase
    end
  end

  // Control registers with asynchronous reset to their parameterised values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q     <= RESET_OUT[WIDTH-1:0];
      dir_q     <= RESET_DIR[WIDTH-1:0];
      irqmask_q <= '0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      irqmask_q <= irqmask_d;
    end
  end

  // Read mux: DATA shows the driven value on outputs, the pin on inputs.
  always_comb begin
    rd_val = '0;
    case (address)
      GPIO_DATA:    rd_val = (dir_q & out_q) | (~dir_q & in_sync);
      GPIO_DIR:     rd_val = dir_q;
      GPIO_IRQMASK: rd_val = irqmask_q;
      GPIO_EDGECAP: rd_val = edgecap;
      default:      rd_val = '0;
    endcase
    readdata = '0;
    readdata[WIDTH-1:0] = rd_val;
  end

  assign out_port = out_q;
  assign oe       = dir_q;
  assign irq      = |(edgecap & irqmask_q);

endmodule

// File: tb/tb_avalon_gpio_ctrl.sv
// Testbench for avalon_gpio_ctrl: two instances (rising-edge and any-edge
// capture) share one bus and one input port and are checked against a
// reference model built from the register-map rules.
module tb_avalon_gpio_ctrl;

  localparam int S = 2;

  // Clock / reset and shared stimulus
  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic [2:0]  address    = '0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = '0;
  logic [7:0]  in_port    = 8'hFF;

  logic [31:0] rd0, rd1;
  logic [7:0]  out0, out1, oe0, oe1;
  logic        irq0, irq1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  avalon_gpio_ctrl #(
    .WIDTH(8), .RESET_OUT(32'h03), .RESET_DIR(32'hFF), .EDGE_TYPE(0), .SYNC_STAGES(S)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in_port),
    .out_port(out0), .oe(oe0), .irq(irq0)
  );

  avalon_gpio_ctrl #(
    .WIDTH(8), .RESET_OUT(32'h03), .RESET_DIR(32'hFF), .EDGE_TYPE(2), .SYNC_STAGES(S)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd1), .in_port(in_port),
    .out_port(out1), .oe(oe1), .irq(irq1)
  );

  // Reference model: inputs are seen S edges late; an edge counts only once
  // both compared samples were taken after reset release.
  logic [7:0] m_out = 8'h03, m_dir = 8'hFF, m_mask = 8'h00;
  logic [7:0] m_cap0 = 8'h00, m_cap1 = 8'h00;
  logic [7:0] hist[$];

  always @(posedge clk or negedge reset_n) begin
    logic [7:0] cur, prv, e0, e1, clr;
    int n;
    if (!reset_n) begin
      m_out = 8'h03; m_dir = 8'hFF; m_mask = 8'h00;
      m_cap0 = 8'h00; m_cap1 = 8'h00;
      hist.delete();
    end else begin
      hist.push_back(in_port);
      n = hist.size();
      e0 = 8'h00; e1 = 8'h00; clr = 8'h00;
      if (n >= S + 2) begin
        cur = hist[n-S-1];
        prv = hist[n-S-2];
        e0 = cur & ~prv;
        e1 = cur ^ prv;
      end
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_out = writedata[7:0];
          3'd1: m_dir = writedata[7:0];
          3'd2: m_mask = writedata[7:0];
          3'd3: clr = writedata[7:0];
          3'd4: m_out = m_out | writedata[7:0];
          3'd5: m_out = m_out & ~writedata[7:0];
          default: ;
        endcase
      end
      m_cap0 = (m_cap0 & ~clr) | e0;
      m_cap1 = (m_cap1 & ~clr) | e1;
    end
  end

  function automatic logic [7:0] model_sync();
    int idx;
    idx = hist.size() - S;
    return (idx >= 0) ? hist[idx] : 8'h00;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a, input logic [7:0] cap);
    logic [7:0] v;
    case (a)
      3'd0: v = (m_dir & m_out) | (~m_dir & model_sync());
      3'd1: v = m_dir;
      3'd2: v = m_mask;
      3'd3: v = cap;
      default: v = 8'h00;
    endcase
    return {24'h0, v};
  endfunction

  // Scoreboard comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    #1;
    check({tag, ".out0"}, {24'h0, out0}, {24'h0, m_out});
    check({tag, ".oe0"},  {24'h0, oe0},  {24'h0, m_dir});
    check({tag, ".out1"}, {24'h0, out1}, {24'h0, m_out});
    check({tag, ".oe1"},  {24'h0, oe1},  {24'h0, m_dir});
    check({tag, ".irq0"}, {31'h0, irq0}, {31'h0, |(m_cap0 & m_mask)});
    check({tag, ".irq1"}, {31'h0, irq1}, {31'h0, |(m_cap1 & m_mask)});
    check({tag, ".rd0"},  rd0, model_read(address, m_cap0));
    check({tag, ".rd1"},  rd1, model_read(address, m_cap1));
  endtask

  // Driver tasks
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    #1;
  endtask

  task automatic bus_read(input logic [2:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset with inputs held high through release
    step(3);
    bus_read(3'd0);
    check("reset.out_port", {24'h0, out0}, 32'h03);
    check("reset.oe", {24'h0, oe0}, 32'hFF);
    check("reset.irq0", {31'h0, irq0}, 32'h0);
    check("reset.irq1", {31'h0, irq1}, 32'h0);
    check("reset.rd_data", rd0, 32'h00000003);
    check_model("reset");
    reset_n = 1'b1;

    // Warm-up: no spurious captures with mask fully open
    bus_write(3'd2, 32'hFF);
    step(5);
    bus_read(3'd3);
    check("warm.cap0", rd0, 32'h0);
    check("warm.cap1", rd1, 32'h0);
    check("warm.irq0", {31'h0, irq0}, 32'h0);
    check("warm.irq1", {31'h0, irq1}, 32'h0);
    check_model("warm");
    bus_write(3'd2, 32'h00);

    // OUTSET / OUTCLR
    bus_write(3'd0, 32'hA5);
    bus_write(3'd4, 32'h0A);
    check("outset", {24'h0, out0}, 32'hAF);
    bus_write(3'd5, 32'h21);
    check("outclr", {24'h0, out0}, 32'h8E);
    check_model("setclr");
    bus_read(3'd4);
    check("rd_outset", rd0, 32'h0);
    bus_read(3'd5);
    check("rd_outclr", rd0, 32'h0);

    // Direction mixing
    bus_write(3'd1, 32'h0F);
    bus_write(3'd0, 32'hFF);
    in_port = 8'h30;
    step(S + 1);
    bus_read(3'd0);
    check("dir_mix", rd0, 32'h3F);
    check_model("dir_mix");

    // Rising edge raises irq, write-1-to-clear drops it
    in_port = 8'h00;
    step(4);
    bus_write(3'd3, 32'hFF);
    bus_write(3'd2, 32'h01);
    check("pre_edge.irq0", {31'h0, irq0}, 32'h0);
    in_port = 8'h01;
    step(S);
    bus_read(3'd3);
    check("edge_early.cap0", rd0, 32'h0);
    check("edge_early.irq0", {31'h0, irq0}, 32'h0);
    step(1);
    bus_read(3'd3);
    check("edge.cap0", rd0, 32'h01);
    check("edge.irq0", {31'h0, irq0}, 32'h1);
    check_model("edge");
    bus_write(3'd3, 32'h01);
    check("clr.irq0", {31'h0, irq0}, 32'h0);
    check_model("clr");

    // Clear of bit2 coinciding with a new bit2 edge
    in_port = 8'h05;
    step(4);
    bus_read(3'd3);
    check("simul_pre.cap0", rd0 & 32'h04, 32'h04);
    in_port = 8'h01;
    step(4);
    in_port = 8'h05;
    step(S);
    bus_write(3'd3, 32'h04);
    bus_read(3'd3);
    check("simul.cap0", rd0 & 32'h04, 32'h04);
    check("simul.cap1", rd1 & 32'h04, 32'h04);
    check_model("simul");

    // Randomised traffic with a mid-run asynchronous reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        reset_n = 1'b0;
        #1;
        check("async_rst.out", {24'h0, out0}, 32'h03);
        check("async_rst.oe", {24'h0, oe0}, 32'hFF);
        check("async_rst.irq1", {31'h0, irq1}, 32'h0);
        step(2);
        reset_n = 1'b1;
      end
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = $urandom;
      if ($urandom_range(0, 9) < 3) in_port = 8'($urandom);
      check_model("rand");
      @(negedge clk);
    end
    chipselect = 1'b0; write_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/avalon_gpio_ctrl.md
Name: avalon_gpio_ctrl

Overview:
- Parametrised Avalon-MM slave GPIO controller for the Nios II system; successor to the fixed 3-bit output-only control PIO.
- Provides per-bit direction, atomic set/clear of output bits, synchronised inputs, edge capture and a maskable level interrupt to the CPU.
- Sits on the system interconnect; zero-wait-state reads; one IRQ line.

Parameters:
- WIDTH, 8, number of GPIO bits; legal range 1..32.
- RESET_OUT, 0, reset value of the output data register (WIDTH bits).
- RESET_DIR, 0, reset value of the direction register; 1 = output.
- EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 any.
- SYNC_STAGES, 2, input synchroniser depth; legal range 2..4.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset; clock clk.
- address  in  3  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address; bits above WIDTH are always 0.
- in_port  in  WIDTH  asynchronous external inputs.
- out_port  out  WIDTH  output data register.
- oe  out  WIDTH  per-bit output enable; equals the direction register.
- irq  out  1  interrupt request, active high.

Behaviour:
- Register map, word addresses:
  - 0 DATA: read returns per bit dir ? out_reg : in_sync; write loads out_reg.
  - 1 DIR: read/write.
  - 2 IRQMASK: read/write.
  - 3 EDGECAP: read; write-1-to-clear.
  - 4 OUTSET: write only; out_reg |= wd.
  - 5 OUTCLR: write only; out_reg &= ~wd.
  - 6, 7 and reads of 4/5 return 0; writes to 6 and 7 are ignored.
- Writes take effect on the clk edge where the write strobe is high; the value is visible on out_port/oe and on readback the next cycle. Only writedata[WIDTH-1:0] is used.
- Input path:
  - in_port passes through a SYNC_STAGES flop chain, giving in_sync.
  - A further flop holds in_prev.
  - Edge detect:
    - rising: in_sync & ~in_prev.
    - falling: ~in_sync & in_prev.
    - any: XOR of the two.
  - Edge detection is independent of DIR.
- Warm-up counter:
  - Reset to 0; increments each cycle until it reaches SYNC_STAGES+1, then holds.
  - Edge detection is suppressed while count < SYNC_STAGES+1, so no spurious edges are captured after reset.
- EDGECAP next state = (EDGECAP & ~clr_mask) | edge_det.
  - clr_mask = wd when EDGECAP is written; 0 otherwise.
  - A new edge in the same cycle as a clear of that bit: the set wins.
- irq = |(EDGECAP & IRQMASK), driven combinationally from registers.
  - Unmasking a bit with a pending capture asserts irq in the next cycle, after the IRQMASK write commits.
- Reset values:
  - out_reg = RESET_OUT; DIR = RESET_DIR.
  - IRQMASK = 0; EDGECAP = 0.
  - Synchroniser and in_prev = 0; warm-up counter = 0.
  - Resulting outputs: out_port = RESET_OUT, oe = RESET_DIR, irq = 0.
- Reset asserted mid-operation clears all state immediately (asynchronously). Deassertion is synchronous to clk, handled upstream.
- Reads have no side effects; a read and a capture in the same cycle return the pre-edge value.

Decomposition:
- Shared package gpio_pkg: register address constants (GPIO_DATA=0 .. GPIO_OUTCLR=5) and EDGE_* encodings.
- One natural sub-module, gpio_edge_capture: synchroniser, in_prev register, warm-up counter, edge detect and EDGECAP register, with clr_mask as an input. The top level holds the bus decode, out_reg, DIR, IRQMASK and the read mux.

Test Plan:
- Reset (WIDTH=8, RESET_OUT=0x03, RESET_DIR=0xFF) -> out_port=0x03, oe=0xFF, irq=0; read addr 0 = 0x00000003.
- OUTSET and OUTCLR:
  - Write DATA=0xA5, then OUTSET 0x0A -> out_port=0xAF.
  - Then OUTCLR 0x21 -> out_port=0x8E.
  - Readback of addresses 4 and 5 = 0.
- Direction mixing:
  - Set DIR=0x0F, out_reg=0xFF, hold in_port=0x30.
  - Read DATA after SYNC_STAGES+1 cycles -> 0x3F.
- Rising edge IRQ:
  - Set IRQMASK=0x01; in_port bit0 goes 0->1.
  - EDGECAP bit0 set SYNC_STAGES+1 cycles later and irq rises with it.
  - Write EDGECAP=0x01 -> irq=0 the next cycle.
- Simultaneous events: an EDGECAP clear of bit2 coincides with a new bit2 edge -> bit2 remains 1.
- Post-reset warm-up: in_port=0xFF held through reset release -> EDGECAP stays 0x00 and irq stays 0. Repeat with EDGE_TYPE=2 (any edge) with the same result.
